// File: rtl/uart_rx_core.sv
// Oversampling 8N1-style UART receiver driven by a divider clock-enable.
// Start-bit qualification, mid-bit 3-sample majority vote, framing/break detection.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_clken,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           win_q, win_d;
    logic                 meta_q, meta_d;
    logic                 rxd_s_q, rxd_s_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 vote;

    assign vote = (win_q[0] & win_q[1]) |
                  (win_q[0] & win_q[2]) |
                  (win_q[1] & win_q[2]);

    always_comb begin
        state_d        = state_q;
        tick_d         = tick_q;
        bidx_d         = bidx_q;
        shreg_d        = shreg_q;
        win_d          = win_q;
        meta_d         = rxd;
        rxd_s_d        = meta_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        if (sample_clken) begin
            win_d  = {win_q[1:0], rxd_s_q};
            tick_d = (tick_q == TICK_END) ? '0 : tick_q + TW'(1);
            unique case (state_q)
                S_IDLE: begin
                    tick_d = '0;
                    if (!rxd_s_q) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bidx_d  = '0;
                        state_d = vote ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_END) begin
                        shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                        bidx_d  = bidx_q + BW'(1);
                        if (bidx_q == BIDX_LAST) begin
                            bidx_d  = '0;
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        if (vote) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            rx_frame_err_d = 1'b1;
                            state_d        = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Stay here while the line is held low so a break yields one error only
                    tick_d = '0;
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    tick_d  = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            tick_q         <= '0;
            bidx_q         <= '0;
            shreg_q        <= '0;
            win_q          <= 3'b111;
            meta_q         <= 1'b1;
            rxd_s_q        <= 1'b1;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            bidx_q         <= bidx_d;
            shreg_q        <= shreg_d;
            win_q          <= win_d;
            meta_q         <= meta_d;
            rxd_s_q        <= rxd_s_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule
